scan_capture: RTL and testbench

- Receive side of the life engine's LED-matrix scan interface (one-hot `row` strobe plus `col` data).
- Watches the multiplexed scan, rebuilds complete frames in a ping-pong frame buffer and exposes the last complete frame through a registered random-access read port.
- Checks scan-sequence integrity.
- Used as the on-chip/bench monitor that turns scan output back into a generation image.

---
 rtl/scan_capture.sv | 120 ++++++++++++
 tb/tb_scan_capture.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scan_capture.sv
// scan_capture: rebuilds LED-matrix scan frames into a ping-pong buffer and serves the last complete frame
module scan_capture #(
  parameter int X     = 16,
  parameter int Y     = 16,
  parameter int LOG2X = 4,
  parameter int LOG2Y = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Y-1:0]     row,
  input  logic [X-1:0]     col,
  input  logic             err_clr,
  input  logic [LOG2Y-1:0] rd_addr,
  output logic [X-1:0]     rd_data,
  output logic             frame_valid,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             scan_err,
  output logic [LOG2Y-1:0] cur_row
);
  typedef enum logic {SYNC, CAPTURE} state_e;
  if ((1 << LOG2X) < X || (1 << LOG2Y) < Y) begin : g_bad_params
    $error("scan_capture: LOG2X/LOG2Y too small for X/Y");
  end
  state_e           state_q, state_d;
  logic [LOG2Y-1:0] cur_row_q, cur_row_d;
  logic             wr_bank_q, wr_bank_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             scan_err_q, scan_err_d;
  logic [X-1:0]     rd_data_q, rd_data_d;
  logic [X-1:0]     mem_q [2][Y];
  logic [LOG2Y-1:0] row_idx;
  logic             blank, onehot, last, err, we, we_bank;
  assign blank  = row == '0;
  assign onehot = !blank && (row & (row - Y'(1))) == '0;
  assign last   = 32'(cur_row_q) == Y - 1;
  // decode the strobed row index (meaningful only when onehot)
  always_comb begin
    row_idx = '0;
    for (int i = 0; i < Y; i++) if (row[i]) row_idx = LOG2Y'(i);
  end
  // scan sequencer: row tracking, commit on row 0 after the last row, error on any out-of-order strobe
  always_comb begin
    state_d       = state_q;
    cur_row_d     = cur_row_q;
    wr_bank_d     = wr_bank_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err           = 1'b0;
    we            = 1'b0;
    we_bank       = wr_bank_q;
    if (!blank) begin
      if (state_q == SYNC) begin
        if (onehot && row_idx == '0) begin
          we        = 1'b1;
          cur_row_d = '0;
          state_d   = CAPTURE;
        end
      end else if (!onehot) begin
        err = 1'b1;
      end else if (row_idx == cur_row_q) begin
        we = 1'b1;
      end else if (!last && row_idx == cur_row_q + LOG2Y'(1)) begin
        we        = 1'b1;
        cur_row_d = row_idx;
      end else if (last && row_idx == '0) begin
        we            = 1'b1;
        we_bank       = ~wr_bank_q;
        wr_bank_d     = ~wr_bank_q;
        cur_row_d     = '0;
        frame_done_d  = 1'b1;
        frame_cnt_d   = frame_cnt_q + 16'd1;
        frame_valid_d = 1'b1;
      end else begin
        err = 1'b1;
      end
      if (err) begin
        state_d   = SYNC;
        cur_row_d = '0;
      end
    end
    scan_err_d = err | (scan_err_q & ~err_clr);
    rd_data_d  = (frame_valid_q && 32'(rd_addr) < Y) ? mem_q[~wr_bank_q][rd_addr] : '0;
  end
  // control and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SYNC;
      cur_row_q     <= '0;
      wr_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      scan_err_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cur_row_q     <= cur_row_d;
      wr_bank_q     <= wr_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      scan_err_q    <= scan_err_d;
      rd_data_q     <= rd_data_d;
    end
  end
  // frame memory, not reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (reset && we) mem_q[we_bank][row_idx] <= col;
  end
  assign rd_data     = rd_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign scan_err    = scan_err_q;
  assign cur_row     = cur_row_q;
endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed-vector check of scan_capture frame rebuild, errors, reset and read port
module tb_scan_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] row = '0;
  logic [15:0] col = '0;
  logic        err_clr = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        frame_valid;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        scan_err;
  logic [3:0]  cur_row;
  int          n_cmp = 0;
  int          n_bad = 0;
  scan_capture #(.X(16), .Y(16), .LOG2X(4), .LOG2Y(4)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .err_clr(err_clr), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_valid(frame_valid), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .scan_err(scan_err), .cur_row(cur_row)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic scan(input int r, input logic [15:0] c);
    row = 16'(1) << r;
    col = c;
    tick();
    row = '0;
  endtask
  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    reset = 1'b0;
    row = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  initial begin
    do_reset();
    reset = 1'b0;
    tick();
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    chk("rst_err", 32'(scan_err), 0);
    chk("rst_cur_row", 32'(cur_row), 0);
    reset = 1'b1;
    // test 1: walking-one frame
    for (int i = 0; i < 16; i++) scan(i, 16'(1) << i);
    chk("t1_cur_row15", 32'(cur_row), 15);
    chk("t1_no_done_yet", 32'(frame_done), 0);
    chk("t1_valid_pre", 32'(frame_valid), 0);
    scan(0, 16'h0001);
    chk("t1_done", 32'(frame_done), 1);
    chk("t1_cnt", 32'(frame_cnt), 1);
    chk("t1_valid", 32'(frame_valid), 1);
    chk("t1_cur_row0", 32'(cur_row), 0);
    tick();
    chk("t1_done_pulse", 32'(frame_done), 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      chk($sformatf("t1_rd%0d", i), 32'(rd_data), 32'(1) << i);
    end
    // test 2: held row (last sample wins) and blank gaps
    for (int i = 1; i < 5; i++) begin
      scan(i, 16'h5500 | 16'(i));
      blanks(3);
    end
    scan(5, 16'hAAAA);
    scan(5, 16'hBBBB);
    scan(5, 16'hCCCC);
    scan(5, 16'h1234);
    chk("t2_hold_row", 32'(cur_row), 5);
    blanks(3);
    for (int i = 6; i < 16; i++) begin
      scan(i, 16'h5500 | 16'(i));
      blanks(3);
    end
    scan(0, 16'hF000);
    chk("t2_done", 32'(frame_done), 1);
    chk("t2_cnt", 32'(frame_cnt), 2);
    rd_addr = 4'd5;
    tick();
    chk("t2_rd5", 32'(rd_data), 32'h1234);
    rd_addr = 4'd0;
    tick();
    chk("t2_rd0", 32'(rd_data), 32'h0001);
    rd_addr = 4'd6;
    tick();
    chk("t2_rd6", 32'(rd_data), 32'h5506);
    // test 3: skip row -> error, resync, clean frame, err_clr
    for (int i = 1; i < 4; i++) scan(i, 16'hE000 | 16'(i));
    chk("t3_cur_row3", 32'(cur_row), 3);
    scan(6, 16'hDEAD);
    chk("t3_err", 32'(scan_err), 1);
    chk("t3_no_done", 32'(frame_done), 0);
    for (int i = 1; i < 16; i++) scan(i, 16'hBAD0 | 16'(i));
    chk("t3_sync_no_done", 32'(frame_done), 0);
    chk("t3_sync_cnt", 32'(frame_cnt), 2);
    for (int i = 0; i < 16; i++) scan(i, 16'hC000 | 16'(i));
    scan(0, 16'hC000);
    chk("t3_done", 32'(frame_done), 1);
    chk("t3_cnt", 32'(frame_cnt), 3);
    rd_addr = 4'd3;
    tick();
    chk("t3_rd3", 32'(rd_data), 32'hC003);
    chk("t3_err_sticky", 32'(scan_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(scan_err), 0);
    // test 4: multi-hot error, then error with concurrent err_clr
    scan(1, 16'h0101);
    scan(2, 16'h0202);
    row = 16'h0011;
    tick();
    row = '0;
    chk("t4_err", 32'(scan_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", 32'(scan_err), 0);
    scan(0, 16'h0000);
    scan(1, 16'h0000);
    row = 16'h0011;
    err_clr = 1'b1;
    tick();
    row = '0;
    err_clr = 1'b0;
    chk("t4_err_prio", 32'(scan_err), 1);
    chk("t4_cnt", 32'(frame_cnt), 3);
    // test 5: reset mid-frame 2
    do_reset();
    for (int i = 0; i < 16; i++) scan(i, 16'h1000 | 16'(i));
    scan(0, 16'h1000);
    chk("t5_cnt1", 32'(frame_cnt), 1);
    for (int i = 1; i < 10; i++) scan(i, 16'h1100 | 16'(i));
    chk("t5_cur_row9", 32'(cur_row), 9);
    rd_addr = 4'd2;
    reset = 1'b0;
    tick();
    chk("t5_rd_data", 32'(rd_data), 0);
    chk("t5_valid", 32'(frame_valid), 0);
    chk("t5_cnt", 32'(frame_cnt), 0);
    chk("t5_cur_row", 32'(cur_row), 0);
    chk("t5_err", 32'(scan_err), 0);
    reset = 1'b1;
    tick();
    chk("t5_rd_invalid", 32'(rd_data), 0);
    for (int i = 0; i < 16; i++) scan(i, 16'h2000 | 16'(i));
    scan(0, 16'h3000);
    chk("t5_recnt", 32'(frame_cnt), 1);
    chk("t5_revalid", 32'(frame_valid), 1);
    // test 6: read in the commit cycle
    for (int i = 1; i < 16; i++) scan(i, 16'h3000 | 16'(i));
    rd_addr = 4'd7;
    scan(0, 16'h4000);
    chk("t6_done", 32'(frame_done), 1);
    chk("t6_rd_old", 32'(rd_data), 32'h2007);
    tick();
    chk("t6_rd_new", 32'(rd_data), 32'h3007);
    chk("t6_done_pulse", 32'(frame_done), 0);
    chk("t6_cnt", 32'(frame_cnt), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
